// File: rtl/key_beep_pkg.sv
// key_beep_pkg: shared state encoding, key-index width and C4/D4/E4/F4 half-period table for the key beep sequencer
package key_beep_pkg;
    localparam int KEY_W = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, BEEP = 2'd1, GAP = 2'd2} state_t;
    localparam logic [3:0][31:0] TONE_HALF = {32'd35_793, 32'd37_922, 32'd42_566, 32'd47_778};
endpackage

// File: rtl/key_rr_arbiter.sv
// key_rr_arbiter: combinational 4-way round-robin (req, last in; gnt_idx, gnt_vld out), search starts one past last
module key_rr_arbiter
    import key_beep_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [KEY_W-1:0] last,
    output logic [KEY_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[last + KEY_W'(i + 1)]) begin
                gnt_idx = last + KEY_W'(i + 1);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_beep_sched.sv
// key_beep_sched: round-robin buzzer sequencer (sys_clk, rst, key_flag, key_value in; beep, busy, active_key, grant out); define KEY_BEEP_QUEUE_EN to queue presses while busy
module key_beep_sched
    import key_beep_pkg::*;
#(
    parameter int               NUM_KEYS    = 4,
    parameter int               BEEP_CYCLES = 10_000_000,
    parameter int               GAP_CYCLES  = 2_500_000,
    parameter int               CNT_W       = 32,
    parameter logic [3:0][31:0] TONE_TAB    = TONE_HALF
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic [NUM_KEYS-1:0] key_value,
    output logic                beep,
    output logic                busy,
    output logic [KEY_W-1:0]    active_key,
    output logic                grant
);
    state_t              state;
    logic [NUM_KEYS-1:0] pend;
    logic [NUM_KEYS-1:0] press;
    logic [KEY_W-1:0]    last_grant;
    logic [KEY_W-1:0]    win_idx;
    logic                win_vld;
    logic                accept;
    logic                tone_wrap;
    logic [CNT_W-1:0]    dur_cnt;
    logic [CNT_W-1:0]    gap_cnt;
    logic [CNT_W-1:0]    tone_cnt;
`ifdef KEY_BEEP_QUEUE_EN
    assign accept = 1'b1;
`else
    assign accept = state == IDLE;
`endif
    assign press     = key_flag & ~key_value & {NUM_KEYS{accept}};
    assign tone_wrap = tone_cnt == CNT_W'(TONE_TAB[active_key] - 32'd1);
    key_rr_arbiter u_arb (
        .req     (pend),
        .last    (last_grant),
        .gnt_idx (win_idx),
        .gnt_vld (win_vld)
    );
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= '0;
            last_grant <= KEY_W'(3);
            active_key <= '0;
            grant      <= 1'b0;
            beep       <= 1'b0;
            busy       <= 1'b0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
            tone_cnt   <= '0;
        end else begin
            grant <= 1'b0;
            pend  <= pend | press;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state      <= BEEP;
                        busy       <= 1'b1;
                        grant      <= 1'b1;
                        active_key <= win_idx;
                        last_grant <= win_idx;
                        pend       <= (pend & ~(NUM_KEYS'(1) << win_idx)) | press;
                        dur_cnt    <= CNT_W'(BEEP_CYCLES - 1);
                        tone_cnt   <= '0;
                        beep       <= 1'b0;
                    end
                end
                BEEP: begin
                    tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
                    beep     <= dur_cnt == '0 ? 1'b0 : (tone_wrap ? ~beep : beep);
                    if (dur_cnt == '0) begin
                        state   <= GAP;
                        gap_cnt <= CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        dur_cnt <= dur_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_beep_sched.sv
// tb_key_beep_sched: directed self-checking bench for key_beep_sched with short durations and tone halves 2/3/4/5
module tb_key_beep_sched;
    logic       sys_clk;
    logic       rst;
    logic [3:0] key_flag;
    logic [3:0] key_value;
    logic       beep;
    logic       busy;
    logic [1:0] active_key;
    logic       grant;
    int         total = 0;
    int         bad = 0;

    key_beep_sched #(
        .NUM_KEYS    (4),
        .BEEP_CYCLES (20),
        .GAP_CYCLES  (5),
        .CNT_W       (32),
        .TONE_TAB    ({32'd5, 32'd4, 32'd3, 32'd2})
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_flag   (key_flag),
        .key_value  (key_value),
        .beep       (beep),
        .busy       (busy),
        .active_key (active_key),
        .grant      (grant)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic press(input logic [3:0] m);
        key_flag  = m;
        key_value = ~m;
        @(negedge sys_clk);
        key_flag  = 4'h0;
        key_value = 4'hF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic serve(input int k, input int inj_c, input logic [3:0] inj);
        int half;
        half = k + 2;
        @(negedge sys_clk);
        check("grant", grant, 1);
        check("active_key", active_key, k);
        check("busy_on", busy, 1);
        check("beep_start", beep, 0);
        for (int c = 1; c <= 25; c++) begin
            key_flag  = (c == inj_c) ? inj : 4'h0;
            key_value = ~key_flag;
            @(negedge sys_clk);
            check("beep", beep, (c < 20) ? ((c / half) % 2) : 0);
            check("busy", busy, (c < 25) ? 1 : 0);
            check("grant_low", grant, 0);
        end
        key_flag  = 4'h0;
        key_value = 4'hF;
    endtask

    initial begin
        rst       = 1'b1;
        key_flag  = 4'hF;
        key_value = 4'h0;
        repeat (3) @(negedge sys_clk);
        check("rst_beep", beep, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active_key, 0);
        check("rst_grant", grant, 0);
        check("rst_pend", dut.pend, 0);
        rst       = 1'b0;
        key_flag  = 4'h0;
        key_value = 4'hF;
        repeat (3) begin
            @(negedge sys_clk);
            check("post_rst_grant", grant, 0);
            check("post_rst_busy", busy, 0);
        end
        key_flag  = 4'h1;
        key_value = 4'hF;
        @(negedge sys_clk);
        key_flag  = 4'h0;
        check("release_pend", dut.pend, 0);
        @(negedge sys_clk);
        check("release_grant", grant, 0);

        press(4'b0100);
        check("single_pend", dut.pend, 4'b0100);
        check("single_nogrant", grant, 0);
        serve(2, -1, 4'h0);

        do_reset();
        press(4'b1010);
        check("simul_pend", dut.pend, 4'b1010);
        serve(1, -1, 4'h0);
        serve(3, -1, 4'h0);
        check("simul_pend_empty", dut.pend, 0);
        @(negedge sys_clk);
        check("simul_no_third", grant, 0);

        do_reset();
        press(4'b0100);
        serve(2, 6, 4'b0001);
`ifdef KEY_BEEP_QUEUE_EN
        serve(0, -1, 4'h0);
        check("queue_pend_empty", dut.pend, 0);
`else
        repeat (3) begin
            @(negedge sys_clk);
            check("drop_grant", grant, 0);
            check("drop_busy", busy, 0);
        end
        check("drop_pend", dut.pend, 0);
`endif

        do_reset();
        press(4'b0011);
        @(negedge sys_clk);
        check("mid_grant", grant, 1);
        check("mid_active", active_key, 0);
        repeat (10) @(negedge sys_clk);
        check("mid_beep_before", beep, 1);
        check("mid_pend_before", dut.pend, 4'b0010);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("mid_beep", beep, 0);
        check("mid_busy", busy, 0);
        check("mid_grant_low", grant, 0);
        check("mid_state", 32'(dut.state), 0);
        check("mid_pend", dut.pend, 0);
        repeat (4) begin
            @(negedge sys_clk);
            check("mid_no_regrant", grant, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
